acq_timing_manager: RTL and testbench
=====================================

ACQ_TIMING_MANAGER -- requirements
Module: acq_timing_manager

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, number of sensor channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of acquisition timer and captured times.
REQ-003 SHALL have parameter RATIO_W, default 16, width of user_ratio.
REQ-004 SHALL have port clk  input  1  single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port event_qualifier  input  1  PWM-carrier event strobe.
REQ-007 SHALL have port user_ratio  input  RATIO_W  qualifier events per trigger, minus one.
REQ-008 SHALL have port en_bits  input  NUM_CH  per-channel enable.
REQ-009 SHALL have port done  input  NUM_CH  per-channel conversion-done level.
REQ-010 SHALL have port timeout_cycles  input  CNT_W  acquisition timeout; 0 disables.
REQ-011 SHALL have port flag_clear  input  1  clears sticky flags.
REQ-012 SHALL have port trigger  output  1  one-cycle acquisition-start pulse.
REQ-013 SHALL have port en_out  output  NUM_CH  registered enable snapshot driven to sensors.
REQ-014 SHALL have port sched_isr  output  1  one-cycle interrupt pulse to PS.
REQ-015 SHALL have port busy  output  1  high while in ACQ or DONE.
REQ-016 SHALL have port ch_time  output  NUM_CH*CNT_W  captured time per channel, channel i at [i*CNT_W +: CNT_W].
REQ-017 SHALL have ports timeout_flag and overrun_flag  output  1 each  sticky status.

Function
REQ-018 Ratio counter SHALL increment on each event_qualifier cycle; on a qualifier cycle with count == user_ratio, trigger = 1 for that next cycle only and count returns to 0; user_ratio = 0 triggers on every qualifier.
REQ-019 FSM SHALL have states IDLE, ACQ, DONE; reset state IDLE.
REQ-020 IDLE + trigger with en_bits != 0 SHALL go to ACQ, snapshot en_bits into en_out, clear per-channel latches, set timer to 0.
REQ-021 IDLE + trigger with en_bits == 0 SHALL pulse sched_isr next cycle, stay IDLE, leave ch_time unchanged.
REQ-022 In ACQ, timer SHALL increment by 1 per cycle, reading 1 on first ACQ cycle, saturating at all-ones.
REQ-023 In ACQ, first cycle an enabled, unlatched channel has done = 1 SHALL latch it and capture current timer value into its ch_time; later done activity on that channel ignored.
REQ-024 done asserted in the trigger cycle SHALL be ignored; sampling begins first ACQ cycle.
REQ-025 Disabled channels SHALL never capture; their ch_time holds its previous value.
REQ-026 When all snapshot channels are latched (including same-cycle multiple dones), FSM SHALL go to DONE.
REQ-027 When timeout_cycles != 0 and timer == timeout_cycles with channels unlatched, SHALL set timeout_flag, write all-ones to each unlatched enabled ch_time, go to DONE; completion on the same cycle as timeout takes priority (no timeout).
REQ-028 DONE SHALL last exactly one cycle with sched_isr = 1, then return to IDLE and clear en_out.
REQ-029 Trigger arriving in ACQ or DONE SHALL be ignored for FSM and set overrun_flag.
REQ-030 en_bits changes during ACQ SHALL have no effect until next trigger.
REQ-031 flag_clear SHALL clear both sticky flags; a set event in the same cycle wins.

Reset
REQ-032 On rst_n low, asynchronously: state IDLE, ratio count 0, timer 0, trigger 0, sched_isr 0, busy 0, en_out 0, all ch_time 0, latches 0, both flags 0.
REQ-033 Reset mid-ACQ SHALL abort with no sched_isr pulse on release.

Structure
REQ-034 FSM state enum and default parameter constants SHALL live in shared package acq_timing_pkg.
REQ-035 Ratio divider SHALL be sub-module event_ratio_divider (event_qualifier, user_ratio -> trigger).

Verification
REQ-036 user_ratio=3, continuous qualifier every 10 cycles -> trigger pulse every 4th qualifier, width 1 cycle.
REQ-037 NUM_CH=6, en_bits=0x21, done[0] at ACQ cycle 5, done[5] at cycle 12 -> ch_time[0]=5, ch_time[5]=12, sched_isr pulse one cycle after cycle 12.
REQ-038 en_bits=0x03, timeout_cycles=20, only done[0] at cycle 7 -> ch_time[0]=7, ch_time[1]=all-ones, timeout_flag=1, one sched_isr.
REQ-039 Trigger during ACQ -> overrun_flag=1, captured times unaffected; flag_clear -> 0.
REQ-040 en_bits=0 with trigger -> sched_isr pulse, busy stays 0; rst_n low mid-ACQ -> all outputs 0, no sched_isr.

Source files
------------

// File: rtl/acq_timing_pkg.sv
// Shared types and default sizing for the acquisition timing manager.
package acq_timing_pkg;

    localparam int unsigned DEF_NUM_CH  = 6;
    localparam int unsigned DEF_CNT_W   = 32;
    localparam int unsigned DEF_RATIO_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_DONE = 2'd2
    } acq_state_e;

endpackage

// File: rtl/event_ratio_divider.sv
// Divides PWM-carrier qualifier events down to a one-cycle acquisition trigger.
module event_ratio_divider
    import acq_timing_pkg::*;
#(
    parameter int unsigned RATIO_W = DEF_RATIO_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               event_qualifier,
    input  logic [RATIO_W-1:0] user_ratio,
    output logic               trigger
);

    logic [RATIO_W-1:0] count_q, count_d;
    logic               trigger_q, trigger_d;

    // >= keeps the divider from running the full counter range if the ratio is lowered
    always_comb begin
        count_d   = count_q;
        trigger_d = 1'b0;
        if (event_qualifier) begin
            if (count_q >= user_ratio) begin
                count_d   = '0;
                trigger_d = 1'b1;
            end else begin
                count_d = count_q + RATIO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            trigger_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            trigger_q <= trigger_d;
        end
    end

    assign trigger = trigger_q;

endmodule

// File: rtl/acq_timing_manager.sv
// Schedules multi-channel sensor acquisitions off the PWM carrier, timestamps
// each channel's conversion-done and raises one interrupt per acquisition.
module acq_timing_manager
    import acq_timing_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned RATIO_W = DEF_RATIO_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    event_qualifier,
    input  logic [RATIO_W-1:0]      user_ratio,
    input  logic [NUM_CH-1:0]       en_bits,
    input  logic [NUM_CH-1:0]       done,
    input  logic [CNT_W-1:0]        timeout_cycles,
    input  logic                    flag_clear,
    output logic                    trigger,
    output logic [NUM_CH-1:0]       en_out,
    output logic                    sched_isr,
    output logic                    busy,
    output logic [NUM_CH*CNT_W-1:0] ch_time,
    output logic                    timeout_flag,
    output logic                    overrun_flag
);

    localparam int unsigned TIME_W = NUM_CH * CNT_W;

    logic trig;

    event_ratio_divider #(
        .RATIO_W(RATIO_W)
    ) u_ratio_div (
        .clk            (clk),
        .rst_n          (rst_n),
        .event_qualifier(event_qualifier),
        .user_ratio     (user_ratio),
        .trigger        (trig)
    );

    acq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [NUM_CH-1:0]   latch_q, latch_d;
    logic [NUM_CH-1:0]   en_out_q, en_out_d;
    logic [TIME_W-1:0]   ch_time_q, ch_time_d;
    logic                sched_isr_q, sched_isr_d;
    logic                busy_q, busy_d;
    logic                timeout_flag_q, timeout_flag_d;
    logic                overrun_flag_q, overrun_flag_d;

    logic [CNT_W-1:0]    timer_inc;
    logic [NUM_CH-1:0]   hit;
    logic                to_set;
    logic                ov_set;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        latch_d     = latch_q;
        en_out_d    = en_out_q;
        ch_time_d   = ch_time_q;
        sched_isr_d = 1'b0;
        to_set      = 1'b0;
        ov_set      = 1'b0;
        hit         = '0;
        // Timer value as seen during the current ACQ cycle (1 on the first one)
        timer_inc   = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    if (en_bits != '0) begin
                        state_d  = ST_ACQ;
                        en_out_d = en_bits;
                        latch_d  = '0;
                        timer_d  = '0;
                    end else begin
                        sched_isr_d = 1'b1;
                    end
                end
            end
            ST_ACQ: begin
                ov_set  = trig;
                timer_d = timer_inc;
                hit     = en_out_q & ~latch_q & done;
                latch_d = latch_q | hit;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (hit[i]) begin
                        ch_time_d[i*CNT_W +: CNT_W] = timer_inc;
                    end
                end
                // Completion outranks a timeout landing on the same cycle
                if ((latch_d & en_out_q) == en_out_q) begin
                    state_d     = ST_DONE;
                    sched_isr_d = 1'b1;
                end else if ((timeout_cycles != '0) && (timer_inc == timeout_cycles)) begin
                    state_d     = ST_DONE;
                    sched_isr_d = 1'b1;
                    to_set      = 1'b1;
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (en_out_q[i] && !latch_d[i]) begin
                            ch_time_d[i*CNT_W +: CNT_W] = '1;
                        end
                    end
                end
            end
            ST_DONE: begin
                ov_set   = trig;
                state_d  = ST_IDLE;
                en_out_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d         = (state_d != ST_IDLE);
        timeout_flag_d = to_set | (timeout_flag_q & ~flag_clear);
        overrun_flag_d = ov_set | (overrun_flag_q & ~flag_clear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            latch_q        <= '0;
            en_out_q       <= '0;
            ch_time_q      <= '0;
            sched_isr_q    <= 1'b0;
            busy_q         <= 1'b0;
            timeout_flag_q <= 1'b0;
            overrun_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            latch_q        <= latch_d;
            en_out_q       <= en_out_d;
            ch_time_q      <= ch_time_d;
            sched_isr_q    <= sched_isr_d;
            busy_q         <= busy_d;
            timeout_flag_q <= timeout_flag_d;
            overrun_flag_q <= overrun_flag_d;
        end
    end

    assign trigger      = trig;
    assign en_out       = en_out_q;
    assign sched_isr    = sched_isr_q;
    assign busy         = busy_q;
    assign ch_time      = ch_time_q;
    assign timeout_flag = timeout_flag_q;
    assign overrun_flag = overrun_flag_q;

endmodule

// File: tb/tb_acq_timing_manager.sv
// Randomized bench for acq_timing_manager against a per-acquisition reference model.
module tb_acq_timing_manager;

    localparam int unsigned NUM_CH  = 6;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned RATIO_W = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    event_qualifier = 1'b0;
    logic [RATIO_W-1:0]      user_ratio = '0;
    logic [NUM_CH-1:0]       en_bits = '0;
    logic [NUM_CH-1:0]       done = '0;
    logic [CNT_W-1:0]        timeout_cycles = '0;
    logic                    flag_clear = 1'b0;
    logic                    trigger;
    logic [NUM_CH-1:0]       en_out;
    logic                    sched_isr;
    logic                    busy;
    logic [NUM_CH*CNT_W-1:0] ch_time;
    logic                    timeout_flag;
    logic                    overrun_flag;

    acq_timing_manager #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .RATIO_W(RATIO_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .event_qualifier(event_qualifier),
        .user_ratio     (user_ratio),
        .en_bits        (en_bits),
        .done           (done),
        .timeout_cycles (timeout_cycles),
        .flag_clear     (flag_clear),
        .trigger        (trigger),
        .en_out         (en_out),
        .sched_isr      (sched_isr),
        .busy           (busy),
        .ch_time        (ch_time),
        .timeout_flag   (timeout_flag),
        .overrun_flag   (overrun_flag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: acq_k = 0 idle, 1..end_k acquiring, end_k+1 interrupt cycle
    int               acq_k;
    int               end_k;
    bit               acq_timed;
    logic [NUM_CH-1:0] snap;
    int               dcyc[NUM_CH];
    logic [CNT_W-1:0] exp_time[NUM_CH];
    bit               exp_trig, exp_isr, exp_tf, exp_of;
    int               qcount;
    int               cyc;

    // Stimulus knobs
    int               q_period, q_pct, clr_pct, rst_permille;
    bit               forced, req_rst, rst_in_acq;
    logic [NUM_CH-1:0] f_en;
    int               f_d[NUM_CH];
    int               f_to;

    task automatic model_reset();
        acq_k    = 0;
        exp_trig = 1'b0;
        exp_isr  = 1'b0;
        exp_tf   = 1'b0;
        exp_of   = 1'b0;
        qcount   = 0;
        for (int i = 0; i < NUM_CH; i++) exp_time[i] = '0;
    endtask

    task automatic check_outputs();
        chk("trigger", 64'(trigger), 64'(exp_trig));
        chk("busy", 64'(busy), 64'(acq_k != 0));
        chk("en_out", 64'(en_out), (acq_k != 0) ? 64'(snap) : 64'd0);
        chk("sched_isr", 64'(sched_isr), 64'(exp_isr));
        chk("timeout_flag", 64'(timeout_flag), 64'(exp_tf));
        chk("overrun_flag", 64'(overrun_flag), 64'(exp_of));
        if (acq_k == 0) begin
            for (int i = 0; i < NUM_CH; i++)
                chk($sformatf("ch_time%0d", i), 64'(ch_time[i*CNT_W +: CNT_W]), 64'(exp_time[i]));
        end
    endtask

    // Plan a whole acquisition up front: done cycle per channel, end cycle, final times
    task automatic start_acq();
        int  to, c;
        bit  allcap;
        snap   = en_bits;
        to     = forced ? f_to : (($urandom_range(2) == 0) ? 0 : int'($urandom_range(30, 3)));
        allcap = 1'b1;
        c      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            dcyc[i] = 0;
            if (snap[i]) begin
                if (forced) dcyc[i] = f_d[i];
                else if (to != 0 && $urandom_range(4) == 0) dcyc[i] = 0;
                else dcyc[i] = int'($urandom_range(35, 1));
                if (dcyc[i] == 0) allcap = 1'b0;
                else if (dcyc[i] > c) c = dcyc[i];
            end
        end
        if (allcap && (to == 0 || c <= to)) begin
            end_k     = c;
            acq_timed = 1'b0;
        end else begin
            end_k     = to;
            acq_timed = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (snap[i])
                exp_time[i] = (dcyc[i] != 0 && dcyc[i] <= end_k) ? CNT_W'(dcyc[i]) : '1;
        end
        timeout_cycles = CNT_W'(to);
    endtask

    task automatic step();
        bit q, clr, do_rst, nxt_isr, nxt_trig, to_set, ov_set, was_rst;
        int nxt_k;
        @(negedge clk);
        check_outputs();
        was_rst = !rst_n;
        if (was_rst) rst_n = 1'b1;
        do_rst = !was_rst && (req_rst || (rst_in_acq && acq_k == 3) ||
                 (rst_permille != 0 && int'($urandom_range(999)) < rst_permille));

        nxt_isr = 1'b0;
        to_set  = 1'b0;
        ov_set  = 1'b0;
        nxt_k   = acq_k;
        en_bits = forced ? f_en : (($urandom_range(7) == 0) ? '0 : NUM_CH'($urandom));
        done    = NUM_CH'($urandom);
        if (acq_k == 0) begin
            if (exp_trig) begin
                if (en_bits != '0) begin
                    start_acq();
                    nxt_k = 1;
                end else begin
                    nxt_isr = 1'b1;
                end
            end
        end else begin
            ov_set = exp_trig;
            if (acq_k <= end_k) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (snap[i]) begin
                        if (dcyc[i] != 0 && acq_k == dcyc[i]) done[i] = 1'b1;
                        else if (dcyc[i] != 0 && acq_k > dcyc[i]) done[i] = 1'($urandom);
                        else done[i] = 1'b0;
                    end
                end
                if (acq_k == end_k) begin
                    nxt_isr = 1'b1;
                    to_set  = acq_timed;
                end
                nxt_k = acq_k + 1;
            end else begin
                nxt_k = 0;
            end
        end

        if (do_rst) q = 1'b0;
        else if (q_period != 0) q = (cyc % q_period) == 0;
        else q = int'($urandom_range(99)) < q_pct;
        event_qualifier = q;
        nxt_trig = 1'b0;
        if (q) begin
            qcount++;
            nxt_trig = (qcount % (int'(user_ratio) + 1)) == 0;
        end

        clr        = int'($urandom_range(99)) < clr_pct;
        flag_clear = clr;
        cyc++;

        if (do_rst) begin
            rst_n = 1'b0;
            model_reset();
        end else begin
            acq_k    = nxt_k;
            exp_isr  = nxt_isr;
            exp_trig = nxt_trig;
            exp_tf   = to_set | (exp_tf & !clr);
            exp_of   = ov_set | (exp_of & !clr);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic reset_with_ratio(input int r);
        req_rst = 1'b1;
        step();
        req_rst    = 1'b0;
        user_ratio = RATIO_W'(r);
    endtask

    initial begin
        model_reset();
        cyc          = 0;
        q_period     = 10;
        q_pct        = 0;
        clr_pct      = 0;
        rst_permille = 0;
        req_rst      = 1'b0;
        rst_in_acq   = 1'b0;
        forced       = 1'b1;
        f_en         = '0;
        f_to         = 0;
        for (int i = 0; i < NUM_CH; i++) f_d[i] = 0;
        user_ratio   = RATIO_W'(3);

        // Divide-by-4 on a 10-cycle carrier, no channels enabled: interrupt only
        run(200);

        // Two channels complete normally
        reset_with_ratio(0);
        q_period = 60;
        f_en     = NUM_CH'(6'h21);
        f_d[0]   = 5;
        f_d[5]   = 12;
        run(200);

        // One channel times out; channel 5 is disabled and holds its time
        f_en   = NUM_CH'(6'h03);
        f_d[0] = 7;
        f_d[1] = 0;
        f_to   = 20;
        run(200);

        // Triggers arriving faster than acquisitions complete
        f_en     = NUM_CH'(6'h21);
        f_d[0]   = 5;
        f_d[5]   = 12;
        f_to     = 0;
        q_period = 8;
        run(100);
        q_period = 0;
        clr_pct  = 100;
        run(20);
        clr_pct  = 0;

        // Reset in the middle of an acquisition
        q_period   = 50;
        rst_in_acq = 1'b1;
        run(60);
        rst_in_acq = 1'b0;
        run(60);

        // Randomized traffic
        forced = 1'b0;
        for (int s = 0; s < 8; s++) begin
            reset_with_ratio(int'($urandom_range(3)));
            q_period     = 0;
            q_pct        = int'($urandom_range(40, 5));
            clr_pct      = 4;
            rst_permille = 2;
            run(500);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
